// File: rtl/mips_cpu_mem_access_if.sv
// rtl/mips_cpu_mem_access_if.sv - core request/response and Avalon-MM signal bundle for the load/store stage
interface mips_cpu_mem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic        write;
   logic        read;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output address, write, read, writedata, byteenable
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, waitrequest, readdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  address, write, read, writedata, byteenable
   );
endinterface

// File: rtl/mips_cpu_mem_access.sv
// rtl/mips_cpu_mem_access.sv - MIPS load/store stage driving a single aligned Avalon-MM transfer per request
module mips_cpu_mem_access #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input logic                   clk,
   input logic                   rst,
   mips_cpu_mem_access_if.master bus
);
   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic [15:0] wait_cnt;

   logic        misaligned;
   logic        is_store;
   logic [3:0]  be_next;
   logic [31:0] wd_next;
   logic [31:0] lane;
   logic [31:0] load_data;
   logic        timeout_hit;

   assign bus.req_ready = (state == IDLE);
   assign is_store      = (bus.req_op >= OP_SW);

   always_comb begin
      misaligned = 1'b0;
      be_next    = 4'b0000;
      wd_next    = 32'h0;
      case (bus.req_op)
         OP_LW, OP_SW: begin
            misaligned = |bus.req_addr[1:0];
            be_next    = 4'b1111;
            wd_next    = bus.req_wdata;
         end
         OP_LH, OP_LHU, OP_SH: begin
            misaligned = bus.req_addr[0];
            be_next    = 4'b0011 << bus.req_addr[1:0];
            wd_next    = {16'h0, bus.req_wdata[15:0]} << {bus.req_addr[1:0], 3'b000};
         end
         default: begin
            be_next = 4'b0001 << bus.req_addr[1:0];
            wd_next = {24'h0, bus.req_wdata[7:0]} << {bus.req_addr[1:0], 3'b000};
         end
      endcase
   end

   // Shift the addressed byte/halfword down to bit 0 before extending.
   always_comb begin
      lane      = bus.readdata >> {off_q, 3'b000};
      load_data = 32'h0;
      case (op_q)
         OP_LW:   load_data = bus.readdata;
         OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
         OP_LHU:  load_data = {16'h0, lane[15:0]};
         OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
         OP_LBU:  load_data = {24'h0, lane[7:0]};
         default: load_data = 32'h0;
      endcase
   end

   // The cycle that would bring the stall count to the limit is the last one on the bus.
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && bus.waitrequest && (wait_cnt == TIMEOUT_LIM - 16'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         op_q           <= OP_LW;
         off_q          <= 2'b00;
         wait_cnt       <= 16'h0;
         bus.read       <= 1'b0;
         bus.write      <= 1'b0;
         bus.address    <= 32'h0;
         bus.writedata  <= 32'h0;
         bus.byteenable <= 4'b0000;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  op_q           <= bus.req_op;
                  off_q          <= bus.req_addr[1:0];
                  bus.resp_rdata <= 32'h0;
                  if (misaligned) begin
                     bus.resp_err   <= 1'b1;
                     bus.resp_valid <= 1'b1;
                     state          <= RESP;
                  end else begin
                     bus.address    <= {bus.req_addr[31:2], 2'b00};
                     bus.byteenable <= be_next;
                     bus.writedata  <= wd_next;
                     bus.read       <= !is_store;
                     bus.write      <= is_store;
                     bus.resp_err   <= 1'b0;
                     wait_cnt       <= 16'h0;
                     state          <= BUS;
                  end
               end
            end
            BUS: begin
               if (!bus.waitrequest) begin
                  bus.read       <= 1'b0;
                  bus.write      <= 1'b0;
                  bus.resp_rdata <= load_data;
                  bus.resp_err   <= 1'b0;
                  bus.resp_valid <= 1'b1;
                  state          <= RESP;
               end else if (timeout_hit) begin
                  bus.read       <= 1'b0;
                  bus.write      <= 1'b0;
                  bus.resp_rdata <= 32'h0;
                  bus.resp_err   <= 1'b1;
                  bus.resp_valid <= 1'b1;
                  state          <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            RESP: begin
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mips_cpu_mem_access.sv
// tb/tb_mips_cpu_mem_access.sv - directed-vector bench for the MIPS load/store bus stage
module tb_mips_cpu_mem_access;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total  = 0;
   int   passed = 0;

   mips_cpu_mem_access_if bus ();

   mips_cpu_mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input int exp_strobes, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err);
      int   lat;
      int   strobes;
      logic done;
      logic st;
      st = (op >= 3'd5);
      @(negedge clk);
      check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid   = 1'b1;
      bus.req_op      = op;
      bus.req_addr    = addr;
      bus.req_wdata   = wdata;
      bus.readdata    = rdata;
      bus.waitrequest = (waits > 0);
      @(posedge clk);
      lat = 0;
      strobes = 0;
      done = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         bus.req_valid = 1'b0;
         check({tag, " rd&wr"}, 32'(bus.read & bus.write), 32'd0);
         if (bus.read || bus.write) begin
            strobes++;
            check({tag, " write"}, 32'(bus.write), 32'(st));
            check({tag, " addr"}, bus.address, exp_addr);
            check({tag, " be"}, 32'(bus.byteenable), 32'(exp_be));
            check({tag, " wdata"}, bus.writedata, exp_wd);
            bus.waitrequest = (strobes <= waits);
         end
         if (bus.resp_valid) done = 1'b1;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " strobes"}, 32'(strobes), 32'(exp_strobes));
      check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
      bus.waitrequest = 1'b0;
   endtask

   initial begin
      bus.req_valid   = 1'b0;
      bus.req_op      = 3'd0;
      bus.req_addr    = 32'h0;
      bus.req_wdata   = 32'h0;
      bus.waitrequest = 1'b0;
      bus.readdata    = 32'h0;
      repeat (2) @(negedge clk);
      check("rst read", 32'(bus.read), 32'd0);
      check("rst write", 32'(bus.write), 32'd0);
      check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst resp_err", 32'(bus.resp_err), 32'd0);
      check("rst address", bus.address, 32'h0);
      check("rst writedata", bus.writedata, 32'h0);
      check("rst be", 32'(bus.byteenable), 32'd0);
      check("rst rdata", bus.resp_rdata, 32'h0);
      check("rst ready", 32'(bus.req_ready), 32'd1);
      rst = 1'b1;

      run("lw",      3'd0, 32'h100, 32'h0,        32'hDEADBEEF, 0,    32'h100, 4'b1111, 32'h0,        1, 2, 32'hDEADBEEF, 1'b0);
      run("lb",      3'd3, 32'h103, 32'h0,        32'h80112233, 0,    32'h100, 4'b1000, 32'h0,        1, 2, 32'hFFFFFF80, 1'b0);
      run("lbu",     3'd4, 32'h103, 32'h0,        32'h80112233, 0,    32'h100, 4'b1000, 32'h0,        1, 2, 32'h00000080, 1'b0);
      run("lh",      3'd1, 32'h102, 32'h0,        32'h80112233, 0,    32'h100, 4'b1100, 32'h0,        1, 2, 32'hFFFF8011, 1'b0);
      run("lhu",     3'd2, 32'h100, 32'h0,        32'h80112233, 0,    32'h100, 4'b0011, 32'h0,        1, 2, 32'h00002233, 1'b0);
      run("sh wait", 3'd6, 32'h202, 32'h0000ABCD, 32'h0,        3,    32'h200, 4'b1100, 32'hABCD0000, 4, 5, 32'h0,        1'b0);
      run("lw mis",  3'd0, 32'h101, 32'h0,        32'h0,        0,    32'h0,   4'b0000, 32'h0,        0, 1, 32'h0,        1'b1);
      run("sh mis",  3'd6, 32'h203, 32'h1234,     32'h0,        0,    32'h0,   4'b0000, 32'h0,        0, 1, 32'h0,        1'b1);
      run("sw tmo",  3'd5, 32'h300, 32'h12345678, 32'h0,        1000, 32'h300, 4'b1111, 32'h12345678, 4, 5, 32'h0,        1'b1);
      run("lw post", 3'd0, 32'h104, 32'h0,        32'h01020304, 0,    32'h104, 4'b1111, 32'h0,        1, 2, 32'h01020304, 1'b0);

      @(negedge clk);
      bus.req_valid   = 1'b1;
      bus.req_op      = 3'd0;
      bus.req_addr    = 32'h400;
      bus.waitrequest = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("stall read", 32'(bus.read), 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async read", 32'(bus.read), 32'd0);
      check("async address", bus.address, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst no resp", 32'(bus.resp_valid), 32'd0);
      end
      rst = 1'b1;
      bus.waitrequest = 1'b0;
      @(negedge clk);
      check("post rst ready", 32'(bus.req_ready), 32'd1);
      check("post rst resp", 32'(bus.resp_valid), 32'd0);
      run("sb",      3'd7, 32'h7,   32'h5A,       32'h0,        0,    32'h4,   4'b1000, 32'h5A000000, 1, 2, 32'h0,        1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mips_cpu_mem_access.md
Name: mips_cpu_mem_access

Overview:
- Load/store bus stage directly downstream of the MIPS CPU core; it is the only master that drives the Avalon memory-mapped bus.
- Accepts one memory request at a time from the core: load word, halfword or byte (signed or unsigned), or store word, halfword or byte.
- Converts each request into a single aligned 32-bit Avalon read or write, honouring `waitrequest`.
- Returns the extracted and extended load data, or an error flag, to the core through a response strobe.

Parameters:
- `TIMEOUT_CYCLES`, default 0: maximum number of consecutive `waitrequest`-high cycles before the transfer is aborted with an error. 0 disables the timeout. Legal range 0..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_op`  in  3  operation: 0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5=SW, 6=SH, 7=SB.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion strobe.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or timeout; valid while `resp_valid` is high.
- `address`  out  32  Avalon word address; bits [1:0] are always 0.
- `write`  out  1  Avalon write.
- `read`  out  1  Avalon read.
- `waitrequest`  in  1  Avalon slave stall.
- `writedata`  out  32  Avalon write data.
- `byteenable`  out  4  Avalon byte lanes.
- `readdata`  in  32  Avalon read data.

Behaviour:
- Reset: `rst` low forces, immediately and asynchronously: state IDLE; `read`, `write`, `resp_valid`, `resp_err` = 0; `address`, `writedata`, `byteenable`, `resp_rdata` = 0; timeout counter = 0.
- States: IDLE, BUS, RESP.
- IDLE: `req_ready` = 1. The handshake fires on `req_valid` && `req_ready` at a rising edge; op, address and data are latched at that edge.
  - Misaligned request (halfword with addr[0] = 1, or word with addr[1:0] != 0): go to RESP with `resp_err` = 1; no bus cycle is issued.
  - Otherwise: go to BUS.
- Byte ordering is little-endian: byte offset k maps to lanes [8k+7:8k] and to `byteenable` bit k.
  - Word: `byteenable` 1111.
  - Halfword: 0011 at offset 0, 1100 at offset 2.
  - Byte: 0001 shifted left by the offset.
  - `writedata` places the store byte or halfword in the selected lanes; unselected lanes are 0.
- BUS: `address` = {addr[31:2], 2'b00}; `read` or `write` = 1. `address`, `writedata`, `byteenable` and the strobe are held stable while `waitrequest` = 1.
  - The transfer completes in the first cycle with `waitrequest` = 0. `readdata` is sampled in that same cycle.
  - The selected lanes are sign-extended (LH, LB) or zero-extended (LHU, LBU) into `resp_rdata`.
  - Next state: RESP, with `read`/`write` deasserted at that edge.
- Timeout (`TIMEOUT_CYCLES` > 0): a 16-bit counter increments on each BUS cycle with `waitrequest` = 1.
  - When the count reaches `TIMEOUT_CYCLES`, drop `read`/`write` and go to RESP with `resp_err` = 1 and `resp_rdata` = 0.
  - The counter clears on entry to BUS.
- RESP: `resp_valid` = 1 for exactly one cycle, then IDLE. `req_ready` = 0 in BUS and RESP.
- Latency: `resp_valid` is high 2 cycles after the accept edge with zero wait states, plus N cycles for N `waitrequest`-high cycles. A misaligned request gives `resp_valid` 1 cycle after accept.
- Throughput: at most one request per 3 cycles.
- `read` and `write` are never high together, and are never high outside BUS.
- Reset mid-transfer: the transfer is abandoned, strobes drop at once, and no `resp_valid` is produced.
- `req_valid` changes while not ready are ignored.

Test Plan:
- LW 0x00000100, `waitrequest` 0, `readdata` 0xDEADBEEF -> `read`=1 for one cycle, `address` 0x100, `byteenable` 1111; `resp_valid` 2 cycles after accept with `resp_rdata` 0xDEADBEEF, `resp_err` 0.
- LB 0x103, `readdata` 0x80112233 -> `address` 0x100, `byteenable` 1000, `resp_rdata` 0xFFFFFF80. Repeat as LBU -> 0x00000080. LH 0x102 -> 0xFFFF8011.
- SH 0x202, `req_wdata` 0x0000ABCD, `waitrequest` high 3 cycles -> `write` held 4 cycles with `address` 0x200, `byteenable` 1100, `writedata` 0xABCD0000 stable throughout; `resp_valid` 5 cycles after accept, `resp_rdata` 0.
- LW 0x101 and SH 0x203 -> `resp_valid` 1 cycle after accept with `resp_err` 1; `read`/`write` never asserted.
- `TIMEOUT_CYCLES`=4, SW with `waitrequest` stuck at 1 -> `write` high exactly 4 cycles then 0; `resp_valid` with `resp_err` 1. Next LW completes normally.
- `rst` pulled low during a stalled read -> `read` 0 asynchronously, no `resp_valid`. After release, `req_ready` 1 and SB 0x7 with data 0x5A gives `byteenable` 1000, `writedata` 0x5A000000.
